// File: rtl/mrv1_issue_sched.sv
// Round-robin thread picker feeding a registered issue slot; a grant becomes visible one cycle later.
// Backpressure: a valid, unkilled slot with issue_rdy_i low holds its contents and blocks new grants.
module mrv1_issue_sched #(
  parameter  int NUM_THREADS_P   = 8,
  parameter  int NUM_FU_P        = 4,
  parameter  int FLUSH_HOLDOFF_P = 2,
  localparam int TID_WIDTH_LP    = $clog2(NUM_THREADS_P),
  localparam int HOLD_WIDTH_LP   = $clog2(FLUSH_HOLDOFF_P+1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_THREADS_P-1:0]          thr_vld_i,
  input  logic [NUM_THREADS_P-1:0]          thr_conflict_i,
  input  logic [NUM_THREADS_P-1:0]          thr_iq_rdy_i,
  input  logic [NUM_THREADS_P*NUM_FU_P-1:0] thr_fu_req_i,
  input  logic [NUM_FU_P-1:0]               exec_fu_rdy_i,
  input  logic                              flush_vld_i,
  input  logic [TID_WIDTH_LP-1:0]           flush_tid_i,
  output logic [NUM_THREADS_P-1:0]          deq_o,
  output logic                              issue_vld_o,
  input  logic                              issue_rdy_i,
  output logic [TID_WIDTH_LP-1:0]           issue_tid_o,
  output logic [NUM_FU_P-1:0]               issue_fu_req_o
);

  logic [NUM_FU_P-1:0]      fu_req   [NUM_THREADS_P];
  logic [HOLD_WIDTH_LP-1:0] hold_cnt [NUM_THREADS_P];
  logic [NUM_THREADS_P-1:0] elig;
  logic [TID_WIDTH_LP-1:0]  rr_ptr;
  logic [TID_WIDTH_LP-1:0]  grant_tid;
  logic                     grant_vld;
  logic                     slot_killed;
  logic                     load;

  always_comb begin
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      fu_req[t] = thr_fu_req_i[t*NUM_FU_P +: NUM_FU_P];
      elig[t]   = thr_vld_i[t] & ~thr_conflict_i[t] & thr_iq_rdy_i[t]
                & (|(fu_req[t] & exec_fu_rdy_i))
                & (hold_cnt[t] == '0)
                & ~(flush_vld_i & (flush_tid_i == TID_WIDTH_LP'(t)));
    end
  end

  // Search starts just after the last winner; the last winner itself is tried last.
  always_comb begin
    logic [TID_WIDTH_LP-1:0] idx;
    idx       = '0;
    grant_vld = 1'b0;
    grant_tid = '0;
    for (int i = 1; i <= NUM_THREADS_P; i++) begin
      idx = rr_ptr + TID_WIDTH_LP'(i);
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant_tid = idx;
      end
    end
  end

  // A flush aimed at the slot's own thread frees it regardless of issue_rdy_i.
  assign slot_killed = flush_vld_i & issue_vld_o & (issue_tid_o == flush_tid_i);
  assign load        = ~issue_vld_o | issue_rdy_i | slot_killed;

  always_comb begin
    deq_o = '0;
    if (rst_i && load && grant_vld) deq_o[grant_tid] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      issue_vld_o    <= 1'b0;
      issue_tid_o    <= '0;
      issue_fu_req_o <= '0;
      rr_ptr         <= TID_WIDTH_LP'(NUM_THREADS_P-1);
      for (int t = 0; t < NUM_THREADS_P; t++) hold_cnt[t] <= '0;
    end else begin
      if (load) begin
        if (grant_vld) begin
          issue_vld_o    <= 1'b1;
          issue_tid_o    <= grant_tid;
          issue_fu_req_o <= fu_req[grant_tid];
          rr_ptr         <= grant_tid;
        end else begin
          issue_vld_o    <= 1'b0;
        end
      end
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        if (flush_vld_i && (flush_tid_i == TID_WIDTH_LP'(t)))
          hold_cnt[t] <= HOLD_WIDTH_LP'(FLUSH_HOLDOFF_P);
        else if (hold_cnt[t] != '0)
          hold_cnt[t] <= hold_cnt[t] - HOLD_WIDTH_LP'(1);
      end
    end
  end

  a_deq_onehot: assert property (@(posedge clk_i) $onehot0(deq_o));
  a_deq_vld:    assert property (@(posedge clk_i) (deq_o & ~thr_vld_i) == '0);
  a_slot_stable: assert property (@(posedge clk_i) disable iff (!rst_i)
    issue_vld_o & ~issue_rdy_i & ~slot_killed |=> $stable(issue_tid_o) && $stable(issue_fu_req_o));

  for (genvar t = 0; t < NUM_THREADS_P; t++) begin : g_fu_chk
    a_fu_onehot: assert property (@(posedge clk_i) disable iff (!rst_i)
      thr_vld_i[t] |-> $onehot0(thr_fu_req_i[t*NUM_FU_P +: NUM_FU_P]));
  end

endmodule

// File: tb/tb_mrv1_issue_sched.sv
// Bench for mrv1_issue_sched: directed vector table, hand sequences, then random traffic vs a reference model.
module tb_mrv1_issue_sched;

  localparam int NT   = 8;
  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  vld, conf, iqr;
  logic [31:0] fureq;
  logic [3:0]  furdy;
  logic        fl;
  logic [2:0]  ftid;
  logic        irdy;
  logic [7:0]  deq;
  logic        issue_vld;
  logic [2:0]  issue_tid;
  logic [3:0]  issue_fu;

  always #5 clk = ~clk;

  mrv1_issue_sched dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .thr_vld_i      (vld),
    .thr_conflict_i (conf),
    .thr_iq_rdy_i   (iqr),
    .thr_fu_req_i   (fureq),
    .exec_fu_rdy_i  (furdy),
    .flush_vld_i    (fl),
    .flush_tid_i    (ftid),
    .deq_o          (deq),
    .issue_vld_o    (issue_vld),
    .issue_rdy_i    (irdy),
    .issue_tid_o    (issue_tid),
    .issue_fu_req_o (issue_fu)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: slot contents, last winner, and the cycle each thread was last flushed.
  bit         m_known = 0;
  bit         m_vld   = 0;
  int         m_tid   = 0;
  int         m_fu    = 0;
  int         m_rr    = NT-1;
  int         lastf [NT];
  int         cyc     = 0;
  int         m_g;
  bit         m_load;
  logic [7:0] m_exp_deq;

  function automatic bit m_elig(input int t);
    return vld[t] && !conf[t] && iqr[t] && ((fureq[t*4 +: 4] & furdy) != 4'b0)
        && (cyc - lastf[t] > HOLD) && !(fl && (ftid == 3'(t)));
  endfunction

  task automatic model_comb();
    bit killed;
    m_g = -1;
    for (int k = 1; k <= NT; k++) begin
      int t;
      t = (m_rr + k) % NT;
      if (m_g < 0 && m_elig(t)) m_g = t;
    end
    killed    = fl && m_vld && (m_tid == int'(ftid));
    m_load    = !m_vld || irdy || killed;
    m_exp_deq = (rst && m_load && m_g >= 0) ? 8'(1 << m_g) : 8'h00;
  endtask

  task automatic model_update();
    if (!rst) begin
      m_vld = 0; m_tid = 0; m_fu = 0; m_rr = NT-1; m_known = 1;
      for (int t = 0; t < NT; t++) lastf[t] = -1000;
    end else begin
      if (m_load) begin
        if (m_g >= 0) begin
          m_vld = 1; m_tid = m_g; m_fu = int'(fureq[m_g*4 +: 4]); m_rr = m_g;
        end else begin
          m_vld = 0;
        end
      end
      if (fl) lastf[ftid] = cyc;
    end
    cyc++;
  endtask

  task automatic step();
    #1;
    model_comb();
    chk("model.deq", deq, m_exp_deq);
    if (m_known) begin
      chk("model.vld", issue_vld, m_vld);
      chk("model.tid", issue_tid, m_tid);
      chk("model.fu",  issue_fu,  m_fu);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic r, input logic [7:0] v, input logic [7:0] c, input logic [7:0] q,
                       input logic [31:0] f, input logic [3:0] fr, input logic fv,
                       input logic [2:0] ft, input logic ir);
    rst = r; vld = v; conf = c; iqr = q; fureq = f; furdy = fr; fl = fv; ftid = ft; irdy = ir;
  endtask

  task automatic apply_chk(input string nm, input logic [7:0] ed, input logic ev, input logic [2:0] et);
    #1;
    chk({nm, ".deq"}, deq, ed);
    step();
    chk({nm, ".vld"}, issue_vld, ev);
    chk({nm, ".tid"}, issue_tid, et);
  endtask

  typedef struct {
    logic        rst;
    logic [7:0]  vld, conf, iqr;
    logic [31:0] fureq;
    logic [3:0]  furdy;
    logic        fl;
    logic [2:0]  ftid;
    logic        irdy;
    logic [7:0]  exp_deq;
    logic        exp_vld;
    logic [2:0]  exp_tid;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [7:0] v, input logic [7:0] c,
                              input logic [31:0] f, input logic [3:0] fr, input logic ir,
                              input logic [7:0] ed, input logic ev, input logic [2:0] et);
    vec_t x;
    x.rst = r; x.vld = v; x.conf = c; x.iqr = 8'hFF; x.fureq = f; x.furdy = fr;
    x.fl = 1'b0; x.ftid = 3'd0; x.irdy = ir;
    x.exp_deq = ed; x.exp_vld = ev; x.exp_tid = et;
    return x;
  endfunction

  localparam logic [31:0] ALL_FU0 = 32'h1111_1111;

  initial begin
    for (int t = 0; t < NT; t++) lastf[t] = -1000;
    drive(1'b0, 8'hFF, 8'h00, 8'hFF, ALL_FU0, 4'hF, 1'b0, 3'd0, 1'b1);

    // Reset with everything eligible, then a full round-robin sweep 0..7,0.
    tbl.push_back(mk(1'b0, 8'hFF, 8'h00, ALL_FU0, 4'hF, 1'b1, 8'h00, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, 8'hFF, 8'h00, ALL_FU0, 4'hF, 1'b1, 8'h00, 1'b0, 3'd0));
    for (int k = 0; k <= NT; k++)
      tbl.push_back(mk(1'b1, 8'hFF, 8'h00, ALL_FU0, 4'hF, 1'b1, 8'(1 << (k % NT)), 1'b1, 3'(k % NT)));
    // A lone eligible thread wins every cycle.
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1'b1, 8'h20, 8'h00, ALL_FU0, 4'hF, 1'b1, 8'h20, 1'b1, 3'd5));
    // tid1 wants FU2 (not ready), tid6 wants FU0; then FU2 comes ready.
    tbl.push_back(mk(1'b1, 8'h42, 8'h00, 32'h0100_0040, 4'b1011, 1'b1, 8'h40, 1'b1, 3'd6));
    tbl.push_back(mk(1'b1, 8'h02, 8'h00, 32'h0100_0040, 4'b1011, 1'b1, 8'h00, 1'b0, 3'd6));
    tbl.push_back(mk(1'b1, 8'h42, 8'h00, 32'h0100_0040, 4'hF,    1'b1, 8'h02, 1'b1, 3'd1));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].conf, tbl[i].iqr, tbl[i].fureq, tbl[i].furdy,
            tbl[i].fl, tbl[i].ftid, tbl[i].irdy);
      apply_chk($sformatf("tbl%0d", i), tbl[i].exp_deq, tbl[i].exp_vld, tbl[i].exp_tid);
    end

    // Backpressure: slot holds tid2 while tids 3,4 wait.
    drive(1'b1, 8'h04, 8'h00, 8'hFF, ALL_FU0, 4'hF, 1'b0, 3'd0, 1'b1);
    apply_chk("bp.load", 8'h04, 1'b1, 3'd2);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'h18, 8'h00, 8'hFF, ALL_FU0, 4'hF, 1'b0, 3'd0, 1'b0);
      apply_chk("bp.hold", 8'h00, 1'b1, 3'd2);
    end
    drive(1'b1, 8'h18, 8'h00, 8'hFF, ALL_FU0, 4'hF, 1'b0, 3'd0, 1'b1);
    apply_chk("bp.release", 8'h08, 1'b1, 3'd3);

    // Flush of the held slot's thread: tid4 replaces it, tid3 blocked for 3 cycles total.
    drive(1'b1, 8'h18, 8'h00, 8'hFF, ALL_FU0, 4'hF, 1'b1, 3'd3, 1'b0);
    apply_chk("fl.kill", 8'h10, 1'b1, 3'd4);
    for (int k = 0; k < HOLD; k++) begin
      drive(1'b1, 8'h08, 8'h00, 8'hFF, ALL_FU0, 4'hF, 1'b0, 3'd0, 1'b1);
      apply_chk("fl.holdoff", 8'h00, 1'b0, 3'd4);
    end
    drive(1'b1, 8'h08, 8'h00, 8'hFF, ALL_FU0, 4'hF, 1'b0, 3'd0, 1'b1);
    apply_chk("fl.reenable", 8'h08, 1'b1, 3'd3);

    // Conflict on tid0 with rr_ptr at 7, then tid0 waits for 2..7.
    drive(1'b1, 8'h80, 8'h00, 8'hFF, ALL_FU0, 4'hF, 1'b0, 3'd0, 1'b1);
    apply_chk("cf.park", 8'h80, 1'b1, 3'd7);
    drive(1'b1, 8'hFF, 8'h01, 8'hFF, ALL_FU0, 4'hF, 1'b0, 3'd0, 1'b1);
    apply_chk("cf.skip0", 8'h02, 1'b1, 3'd1);
    for (int k = 2; k <= NT; k++) begin
      drive(1'b1, 8'hFF, 8'h00, 8'hFF, ALL_FU0, 4'hF, 1'b0, 3'd0, 1'b1);
      apply_chk("cf.rr", 8'(1 << (k % NT)), 1'b1, 3'(k % NT));
    end

    // Reset while the slot is full discards it without a dequeue.
    drive(1'b0, 8'hFF, 8'h00, 8'hFF, ALL_FU0, 4'hF, 1'b0, 3'd0, 1'b0);
    apply_chk("rst.mid", 8'h00, 1'b0, 3'd0);
    drive(1'b1, 8'hFF, 8'h00, 8'hFF, ALL_FU0, 4'hF, 1'b0, 3'd0, 1'b0);
    apply_chk("rst.first", 8'h01, 1'b1, 3'd0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] f;
      f = '0;
      for (int t = 0; t < NT; t++) begin
        int r;
        r = $urandom_range(0, 4);
        f[t*4 +: 4] = (r == 4) ? 4'b0 : 4'(1 << r);
      end
      drive($urandom_range(0, 99) != 0, 8'($urandom), 8'($urandom & $urandom),
            8'($urandom | $urandom), f, 4'($urandom), $urandom_range(0, 5) == 0,
            3'($urandom), $urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mrv1_issue_sched.md
Name: mrv1_issue_sched

Overview:
Per-cycle thread scheduler for the multithreaded issue stage. It picks one thread per cycle from the per-thread decode-buffer heads using round-robin arbitration. A thread is eligible only if its scoreboard shows no operand conflict, its instruction-track queue can allocate a tag, its requested functional unit is ready, and it is not in post-flush holdoff. The winner is dequeued from its decode buffer and held in a registered issue slot with a valid/ready handshake toward operand read and execute.

Parameters:
NUM_THREADS_P, 8, number of hardware threads (power of two, >=2)
NUM_FU_P, 4, number of functional units
FLUSH_HOLDOFF_P, 2, cycles a thread is blocked after a branch flush (>=1)
TID_WIDTH_LP, $clog2(NUM_THREADS_P), thread-id width
HOLD_WIDTH_LP, $clog2(FLUSH_HOLDOFF_P+1), holdoff counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-low
thr_vld_i  in  NUM_THREADS_P  decode-buffer head valid, per thread
thr_conflict_i  in  NUM_THREADS_P  scoreboard rs/rd conflict on head, per thread
thr_iq_rdy_i  in  NUM_THREADS_P  instruction-track queue can accept, per thread
thr_fu_req_i  in  NUM_THREADS_P*NUM_FU_P  one-hot FU request of each head; thread t at [t*NUM_FU_P +: NUM_FU_P]
exec_fu_rdy_i  in  NUM_FU_P  FU ready
flush_vld_i  in  1  branch flush
flush_tid_i  in  TID_WIDTH_LP  thread being flushed
deq_o  out  NUM_THREADS_P  one-hot decode-buffer dequeue / iqueue tag-allocate pulse (combinational)
issue_vld_o  out  1  issue slot valid (registered)
issue_rdy_i  in  1  downstream accepts issue slot
issue_tid_o  out  TID_WIDTH_LP  thread in issue slot (registered)
issue_fu_req_o  out  NUM_FU_P  FU request of slot (registered)

Behaviour:
- Reset (rst_i==0 at clk edge): issue_vld_o=0, issue_tid_o=0, issue_fu_req_o=0, all holdoff counters=0, rr_ptr=NUM_THREADS_P-1 (first search starts at tid 0). deq_o is forced to 0 while rst_i==0. Reset mid-operation discards the slot with no dequeue.
- Eligibility: elig[t] = thr_vld_i[t] & ~thr_conflict_i[t] & thr_iq_rdy_i[t] & |(thr_fu_req_i[t] & exec_fu_rdy_i) & (hold_cnt[t]==0) & ~(flush_vld_i & flush_tid_i==t).
- Load enable: load = ~issue_vld_o | issue_rdy_i | slot_killed, where slot_killed = flush_vld_i & issue_vld_o & issue_tid_o==flush_tid_i.
- Arbitration: search tids rr_ptr+1, rr_ptr+2, ... modulo NUM_THREADS_P. The first eligible tid is g.
- If load & |elig:
  - deq_o = onehot(g) in the same cycle.
  - Next edge: issue_vld_o<=1, issue_tid_o<=g, issue_fu_req_o<=thr_fu_req_i[g], rr_ptr<=g.
- If load & ~|elig: deq_o=0; issue_vld_o<=0; issue_tid_o, issue_fu_req_o and rr_ptr hold.
- If ~load (slot valid, issue_rdy_i=0, not killed): deq_o=0; all slot outputs and rr_ptr hold stable.
- Latency: eligible head to issue_vld_o is 1 cycle. Back-to-back issue is possible every cycle when issue_rdy_i=1.
- A single eligible thread may win on consecutive cycles; round-robin only affects contention.
- Flush:
  - On flush_vld_i, hold_cnt[flush_tid_i]<=FLUSH_HOLDOFF_P, reloading even if already counting.
  - If slot_killed, the slot is invalidated: another thread may load in the same cycle; otherwise issue_vld_o<=0. This happens regardless of issue_rdy_i, and the killed instruction counts as not accepted downstream.
  - Counters with nonzero value and no flush decrement by 1 per cycle. The thread becomes eligible in the cycle its counter reads 0, i.e. FLUSH_HOLDOFF_P+1 cycles after the flush cycle.
- FU gating uses exec_fu_rdy_i in the grant cycle only. The slot does not re-check FU readiness while held; downstream issue_rdy_i covers that.
- thr_fu_req_i with zero bits set never makes the thread eligible. Multi-hot is illegal (assertion).
- Assertions: deq_o is one-hot or zero; deq_o[t] implies thr_vld_i[t]; issue_tid_o and issue_fu_req_o are stable while issue_vld_o & ~issue_rdy_i & ~slot_killed.

Test Plan:
- Reset with all inputs eligible, then release rst_i -> first grant tid 0, then 1,2,...,7,0 on consecutive cycles with issue_rdy_i=1; deq_o=8'h01,8'h02,...
- Only tid 5 eligible for 4 cycles, issue_rdy_i=1 -> issue_tid_o=5 four times; deq_o=8'h20 each cycle.
- Slot valid tid 2, issue_rdy_i=0 for 3 cycles with tids 3 and 4 eligible -> deq_o=0, issue_tid_o=2 stable; when rdy=1, next grant is tid 3.
- tid 1 eligible but its FU 2 not ready (exec_fu_rdy_i=4'b1011), tid 6 eligible on FU 0 -> grant tid 6; when FU 2 becomes ready, tid 1 is granted next.
- Slot holds tid 3 with issue_rdy_i=0; flush_vld_i with flush_tid_i=3, tid 4 eligible -> same cycle deq_o=onehot(4), slot becomes tid 4. tid 3 is blocked for the flush cycle plus 2 cycles and is eligible again on the 3rd cycle after the flush.
- Contention with tid 0 conflicted (thr_conflict_i[0]=1), rr_ptr=7 -> tid 1 granted. After the conflict clears, tid 0 is granted only after tids 2..7 have had their turn.
